// File: rtl/uart_pkg.sv
// Shared UART definitions: bit timing default, data width and the
// receiver state encoding reused by later UART blocks.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 1250;
  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop resynchronizer for the serial line plus a previous-value
// register; fall pulses for one cycle on a synchronized high-to-low step.
module uart_rx_sync (
  input  logic clock_system,
  input  logic rstn,
  input  logic rx,
  output logic sync,
  output logic fall
);

  logic meta;
  logic prev;

  always_ff @(posedge clock_system or negedge rstn) begin
    if (!rstn) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= rx;
      sync <= meta;
      prev <= sync;
    end
  end

  assign fall = prev & ~sync;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver with mid-bit sampling and one-cycle strobes.
// Define UART_RX_MAJORITY_EN for a 2-of-3 vote at each sample point.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic                      clock_system,
  input  logic                      rstn,
  input  logic                      rx,
  input  logic                      en,
  output logic [UART_DATA_BITS-1:0] data_out,
  output logic                      data_valid,
  output logic                      frame_err,
  output logic                      busy
);

  localparam logic [CNT_W-1:0] BIT_LAST =
    CNT_W'(CLKS_PER_BIT - 1);

  logic sync;
  logic fall;
  logic bit_val;

  uart_rx_sync u_sync (
    .clock_system(clock_system),
    .rstn(rstn),
    .rx(rx),
    .sync(sync),
    .fall(fall)
  );

`ifdef UART_RX_MAJORITY_EN
  // Start decision one cycle later shifts every later decision too.
  localparam logic [CNT_W-1:0] HALF_LAST =
    CNT_W'(CLKS_PER_BIT / 2);

  logic [1:0] hist;

  always_ff @(posedge clock_system or negedge rstn) begin
    if (!rstn) hist <= 2'b11;
    else hist <= {hist[0], sync};
  end

  assign bit_val = (hist[1] & hist[0]) |
                   (hist[1] & sync) |
                   (hist[0] & sync);
`else
  localparam logic [CNT_W-1:0] HALF_LAST =
    CNT_W'(CLKS_PER_BIT / 2 - 1);

  assign bit_val = sync;
`endif

  uart_rx_state_t state;
  logic [CNT_W-1:0] cnt;
  logic [2:0] idx;
  logic [UART_DATA_BITS-1:0] shreg;

  always_ff @(posedge clock_system or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (!en) begin
        state <= IDLE;
        cnt   <= '0;
        idx   <= '0;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (fall) begin
              state <= START;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end
          START: begin
            if (cnt == HALF_LAST) begin
              cnt <= '0;
              if (!bit_val) begin
                state <= DATA;
                idx   <= '0;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DATA: begin
            if (cnt == BIT_LAST) begin
              cnt   <= '0;
              shreg <= {bit_val, shreg[7:1]};
              if (idx == 3'd7) state <= STOP;
              else idx <= idx + 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          STOP: begin
            if (cnt == BIT_LAST) begin
              cnt   <= '0;
              state <= IDLE;
              busy  <= 1'b0;
              if (bit_val) begin
                data_out   <= shreg;
                data_valid <= 1'b1;
              end else begin
                frame_err  <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at 1250 clocks per bit.
// Honours UART_RX_MAJORITY_EN for timing and spike expectations.
module tb_uart_byte_rx;

  localparam int CPB = 1250;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
  localparam logic [7:0] SPIKE_BYTE = 8'h0F;
`else
  localparam int MAJ = 0;
  localparam logic [7:0] SPIKE_BYTE = 8'h0B;
`endif
  localparam int STOP_LAT = 11878 + MAJ;

  logic clock_system = 1'b0;
  logic rstn = 1'b0;
  logic rx = 1'b1;
  logic en = 1'b1;
  logic [7:0] data_out;
  logic data_valid;
  logic frame_err;
  logic busy;

  uart_byte_rx #(
    .CLKS_PER_BIT(CPB),
    .CNT_W(16)
  ) dut (
    .clock_system(clock_system),
    .rstn(rstn),
    .rx(rx),
    .en(en),
    .data_out(data_out),
    .data_valid(data_valid),
    .frame_err(frame_err),
    .busy(busy)
  );

  always #5 clock_system = ~clock_system;

  int cyc = 0;
  always @(posedge clock_system) cyc <= cyc + 1;

  int dv_cnt = 0;
  int fe_cnt = 0;
  int both_cnt = 0;
  int dv_cyc = 0;
  int prev_cyc = 0;
  int fe_cyc = 0;
  logic [7:0] dv_data = 8'h00;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clock_system) begin
    if (data_valid) begin
      dv_cnt = dv_cnt + 1;
      prev_cyc = dv_cyc;
      prev_data = dv_data;
      dv_cyc = cyc;
      dv_data = data_out;
    end
    if (frame_err) begin
      fe_cnt = fe_cnt + 1;
      fe_cyc = cyc;
    end
    if (data_valid && frame_err) both_cnt = both_cnt + 1;
  end

  int tests = 0;
  int fails = 0;
  int t0 = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b,
                      input logic stop,
                      input int spike,
                      input int ncyc);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clock_system);
      if (i == 0) t0 = cyc;
      rx = f[i / CPB] ^ (i == spike);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clock_system);
  endtask

  initial begin
    repeat (3) @(negedge clock_system);
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_valid", 32'(data_valid), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rstn = 1'b1;
    idle(20);

    send(8'hA5, 1'b1, -1, 10 * CPB);
    idle(50);
    check("a5_count", 32'(dv_cnt), 32'd1);
    check("a5_time", 32'(dv_cyc - t0), 32'(STOP_LAT));
    check("a5_data", 32'(dv_data), 32'hA5);
    check("a5_ferr", 32'(fe_cnt), 32'd0);

    @(negedge clock_system);
    t0 = cyc;
    rx = 1'b0;
    repeat (300) @(negedge clock_system);
    rx = 1'b1;
    while (cyc < t0 + 627 + MAJ) @(negedge clock_system);
    check("glitch_busy_hi", 32'(busy), 32'h1);
    @(negedge clock_system);
    check("glitch_busy_lo", 32'(busy), 32'h0);
    idle(200);
    check("glitch_dv", 32'(dv_cnt), 32'd1);
    check("glitch_fe", 32'(fe_cnt), 32'd0);

    send(8'h3C, 1'b0, -1, 10 * CPB);
    idle(50);
    check("ferr_count", 32'(fe_cnt), 32'd1);
    check("ferr_time", 32'(fe_cyc - t0), 32'(STOP_LAT));
    check("ferr_dv", 32'(dv_cnt), 32'd1);
    check("ferr_hold", 32'(data_out), 32'hA5);
    idle(CPB);

    send(8'h00, 1'b1, -1, 10 * CPB);
    send(8'hFF, 1'b1, -1, 10 * CPB);
    idle(50);
    check("b2b_count", 32'(dv_cnt), 32'd3);
    check("b2b_first", 32'(prev_data), 32'h00);
    check("b2b_second", 32'(dv_data), 32'hFF);
    check("b2b_gap", 32'(dv_cyc - prev_cyc), 32'd12500);

    send(8'hFF, 1'b1, -1, 4 * CPB + 600);
    check("pre_rst_busy", 32'(busy), 32'h1);
    rstn = 1'b0;
    repeat (2) @(negedge clock_system);
    check("mid_rst_data", 32'(data_out), 32'h00);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_valid", 32'(data_valid), 32'h0);
    check("mid_rst_ferr", 32'(frame_err), 32'h0);
    rstn = 1'b1;
    idle(20);
    send(8'h5A, 1'b1, -1, 10 * CPB);
    idle(50);
    check("post_rst_count", 32'(dv_cnt), 32'd4);
    check("post_rst_data", 32'(dv_data), 32'h5A);
    check("post_rst_time", 32'(dv_cyc - t0), 32'(STOP_LAT));

    send(8'hFF, 1'b1, -1, CPB + 400);
    check("pre_en_busy", 32'(busy), 32'h1);
    en = 1'b0;
    repeat (3) @(negedge clock_system);
    check("en_abort_busy", 32'(busy), 32'h0);
    en = 1'b1;
    idle(1000);
    check("en_abort_dv", 32'(dv_cnt), 32'd4);
    check("en_abort_hold", 32'(data_out), 32'h5A);

    send(8'h0F, 1'b1, 3 * CPB + CPB / 2, 10 * CPB);
    idle(50);
    check("spike_count", 32'(dv_cnt), 32'd5);
    check("spike_data", 32'(dv_data), 32'(SPIKE_BYTE));
    check("final_fe", 32'(fe_cnt), 32'd1);
    check("never_both", 32'(both_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
